hazard_forward_ctrl: RTL and testbench

//  Parametrised hazard/forwarding controller for the 5-stage datapath (IF/ID/EX/MEM/WB).

---
 rtl/hazard_forward_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// Hazard / forwarding controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Latency: enables, bubble, flush and fa/fb are combinational; st_fwd is one registered cycle.
// Backpressure: stalls PC and IF/ID on load-use, and freezes PC, IF/ID and ID/EX while a multi-cycle op runs.
//
// Optional feature macro: FWD_STORE_EN
//   defined   -> store-data forwarding from MEM/WB (st_fwd), and an extra
//                input id_memwrite so a store whose data register is the
//                in-flight load result does not take a load-use stall.
//   undefined -> st_fwd is tied to 0, and load-then-store stalls as a
//                normal load-use.
//
// Ports
//   clk, reset                    rising-edge clock, synchronous active-high reset
//   id_rn1/id_rn2/id_uses_rn2     ID-stage source registers
//   id_memwrite (FWD_STORE_EN)    ID instruction is a store (rn2 is store data)
//   ex_rn1/ex_rn2/ex_wn           ID/EX sources and destination
//   ex_regwrite/ex_memread        ID/EX RegWrite, MemRead
//   ex_multi                      ID/EX holds a multi-cycle op
//   br_taken                      branch resolved taken in EX
//   mem_wn/mem_regwrite           EX/MEM destination, RegWrite
//   mem_memwrite                  EX/MEM MemWrite
//   wb_wn/wb_regwrite/wb_memtoreg MEM/WB destination, RegWrite, MemToReg
//   pc_write/ifid_write/idex_write pipeline register load enables
//   ctrl_bubble/ifid_flush        zero ID/EX control, clear IF/ID
//   fa/fb                         ALU operand selects: 00 WB, 01 regfile, 10 EX/MEM
//   st_fwd                        store data from MEM/WB (registered)
//   ex_busy                       multi-cycle op in progress
module hazard_forward_ctrl #(
  parameter int RADDR_W = 4,
  parameter int MUL_LAT = 3,
  parameter int R0_ZERO = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [RADDR_W-1:0] id_rn1,
  input  logic [RADDR_W-1:0] id_rn2,
  input  logic               id_uses_rn2,
`ifdef FWD_STORE_EN
  input  logic               id_memwrite,
`endif
  input  logic [RADDR_W-1:0] ex_rn1,
  input  logic [RADDR_W-1:0] ex_rn2,
  input  logic [RADDR_W-1:0] ex_wn,
  input  logic               ex_regwrite,
  input  logic               ex_memread,
  input  logic               ex_multi,
  input  logic               br_taken,
  input  logic [RADDR_W-1:0] mem_wn,
  input  logic               mem_regwrite,
  input  logic               mem_memwrite,
  input  logic [RADDR_W-1:0] wb_wn,
  input  logic               wb_regwrite,
  input  logic               wb_memtoreg,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               idex_write,
  output logic               ctrl_bubble,
  output logic               ifid_flush,
  output logic [1:0]         fa,
  output logic [1:0]         fb,
  output logic               st_fwd,
  output logic               ex_busy
);

  localparam int CNT_W = $clog2(MUL_LAT);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MUL_LAT - 2);

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               drain_q, drain_d;

  logic               multi_start;
  logic               freeze;
  logic               rn1_hazard;
  logic               rn2_hazard;
  logic               load_use;

  // A producer matches a consumer only if it writes and the register is not
  // the hardwired zero register.
  function automatic logic match(input logic [RADDR_W-1:0] r,
                                 input logic [RADDR_W-1:0] w,
                                 input logic               we);
    return we && (r == w) && !((R0_ZERO != 0) && (w == '0));
  endfunction

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic [RADDR_W-1:0] rn,
                                         input logic [RADDR_W-1:0] m_wn,
                                         input logic               m_we,
                                         input logic [RADDR_W-1:0] w_wn,
                                         input logic               w_we);
    if (match(rn, m_wn, m_we)) begin
      return 2'b10;
    end else if (match(rn, w_wn, w_we)) begin
      return 2'b00;
    end else begin
      return 2'b01;
    end
  endfunction

  // The multi-cycle op is still sitting in ID/EX for one cycle after the
  // freeze ends (ID/EX was held through the last busy cycle); drain_q masks
  // ex_multi for that cycle so the same op does not restart the freeze.
  assign multi_start = (state_q == RUN) && ex_multi && !drain_q;
  assign freeze      = (state_q == BUSY) || multi_start;

  assign rn1_hazard = match(id_rn1, ex_wn, ex_regwrite);
`ifdef FWD_STORE_EN
  // Store data is picked up later from MEM/WB, so a store's rn2 never
  // needs to wait on the load.
  assign rn2_hazard = id_uses_rn2 && !id_memwrite && match(id_rn2, ex_wn, ex_regwrite);
`else
  assign rn2_hazard = id_uses_rn2 && match(id_rn2, ex_wn, ex_regwrite);
`endif
  assign load_use = ex_memread && (rn1_hazard || rn2_hazard);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = 1'b0;
    case (state_q)
      RUN: begin
        if (multi_start) begin
          state_d = BUSY;
          cnt_d   = CNT_RELOAD;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RUN;
          drain_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Output steering: reset > freeze > branch flush > load-use > normal.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    ctrl_bubble = 1'b0;
    ifid_flush  = 1'b0;
    ex_busy     = 1'b0;
    fa          = fwd_sel(ex_rn1, mem_wn, mem_regwrite, wb_wn, wb_regwrite);
    fb          = fwd_sel(ex_rn2, mem_wn, mem_regwrite, wb_wn, wb_regwrite);
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      ctrl_bubble = 1'b1;
      ifid_flush  = 1'b1;
      fa          = 2'b01;
      fb          = 2'b01;
    end else if (freeze) begin
      // br_taken is deliberately ignored here: a multi-cycle op is never a branch.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
      ex_busy    = 1'b1;
    end else if (br_taken) begin
      // Wrong-path instructions in IF/ID and ID are squashed, so any load-use
      // against the ID instruction is moot.
      ifid_flush  = 1'b1;
      ctrl_bubble = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ctrl_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

`ifdef FWD_STORE_EN
  // The store's rn2 is not a port once it leaves EX, so keep a MEM-stage copy.
  // Capturing every cycle is safe: only a store in MEM (mem_memwrite) uses it.
  logic [RADDR_W-1:0] mem_rn2_q;
  logic               st_fwd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rn2_q <= '0;
      st_fwd_q  <= 1'b0;
    end else begin
      mem_rn2_q <= ex_rn2;
      // Registered so the select lands with the data-memory write port,
      // which captures the store one cycle after it sits in MEM.
      st_fwd_q  <= mem_memwrite && wb_memtoreg && match(mem_rn2_q, wb_wn, wb_regwrite);
    end
  end

  assign st_fwd = st_fwd_q;
`else
  logic unused_store_inputs;
  assign unused_store_inputs = &{1'b0, mem_memwrite, wb_memtoreg};
  assign st_fwd = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed testbench for hazard_forward_ctrl (RADDR_W=4, MUL_LAT=3, R0_ZERO=1).
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: none; the bench drives every pipeline stage explicitly each cycle.
module tb_hazard_forward_ctrl;

`ifdef FWD_STORE_EN
  localparam bit STF = 1'b1;
`else
  localparam bit STF = 1'b0;
`endif

  // ctl = {pc_write, ifid_write, idex_write, ctrl_bubble, ifid_flush, ex_busy}
  localparam logic [5:0] C_RESET  = 6'b000110;
  localparam logic [5:0] C_NORMAL = 6'b111000;
  localparam logic [5:0] C_LU     = 6'b001100;
  localparam logic [5:0] C_FREEZE = 6'b000001;
  localparam logic [5:0] C_BRANCH = 6'b111110;

  logic       clk;
  logic       reset;
  logic [3:0] id_rn1, id_rn2;
  logic       id_uses_rn2;
  logic       id_memwrite;
  logic [3:0] ex_rn1, ex_rn2, ex_wn;
  logic       ex_regwrite, ex_memread, ex_multi, br_taken;
  logic [3:0] mem_wn;
  logic       mem_regwrite, mem_memwrite;
  logic [3:0] wb_wn;
  logic       wb_regwrite, wb_memtoreg;
  logic       pc_write, ifid_write, idex_write, ctrl_bubble, ifid_flush;
  logic [1:0] fa, fb;
  logic       st_fwd, ex_busy;
  logic [5:0] ctl;

  int total = 0;
  int bad   = 0;

  assign ctl = {pc_write, ifid_write, idex_write, ctrl_bubble, ifid_flush, ex_busy};

  hazard_forward_ctrl #(.RADDR_W(4), .MUL_LAT(3), .R0_ZERO(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rn1       (id_rn1),
    .id_rn2       (id_rn2),
    .id_uses_rn2  (id_uses_rn2),
`ifdef FWD_STORE_EN
    .id_memwrite  (id_memwrite),
`endif
    .ex_rn1       (ex_rn1),
    .ex_rn2       (ex_rn2),
    .ex_wn        (ex_wn),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .ex_multi     (ex_multi),
    .br_taken     (br_taken),
    .mem_wn       (mem_wn),
    .mem_regwrite (mem_regwrite),
    .mem_memwrite (mem_memwrite),
    .wb_wn        (wb_wn),
    .wb_regwrite  (wb_regwrite),
    .wb_memtoreg  (wb_memtoreg),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_write   (idex_write),
    .ctrl_bubble  (ctrl_bubble),
    .ifid_flush   (ifid_flush),
    .fa           (fa),
    .fb           (fb),
    .st_fwd       (st_fwd),
    .ex_busy      (ex_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rn1 = 4'd0; id_rn2 = 4'd0; id_uses_rn2 = 1'b0; id_memwrite = 1'b0;
    ex_rn1 = 4'd0; ex_rn2 = 4'd0; ex_wn = 4'd0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; ex_multi = 1'b0; br_taken = 1'b0;
    mem_wn = 4'd0; mem_regwrite = 1'b0; mem_memwrite = 1'b0;
    wb_wn = 4'd0; wb_regwrite = 1'b0; wb_memtoreg = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    // Hazard-looking inputs must not leak through while in reset.
    ex_rn1 = 4'd5; mem_wn = 4'd5; mem_regwrite = 1'b1;
    ex_multi = 1'b1; br_taken = 1'b1;
    #1;
    total++; if (ctl !== C_RESET) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RESET); end
    total++; if (fa !== 2'b01 || fb !== 2'b01) begin bad++; $display("FAIL reset_fwd got fa=%b fb=%b exp 01/01", fa, fb); end
    tick();
    tick();
    total++; if (st_fwd !== 1'b0) begin bad++; $display("FAIL reset_stfwd got=%b exp=0", st_fwd); end
    reset = 1'b0;
    idle();
    #1;
    total++; if (ctl !== C_NORMAL) begin bad++; $display("FAIL post_reset_ctl got=%b exp=%b", ctl, C_NORMAL); end
  endtask

  // ADD r4,r1,r2 ; SUB r6,r4,r1 ; OR r8,r1,r4
  task automatic test_alu_fwd();
    idle();
    mem_wn = 4'd4; mem_regwrite = 1'b1;
    ex_rn1 = 4'd4; ex_rn2 = 4'd1;
    #1;
    total++; if (fa !== 2'b10 || fb !== 2'b01) begin bad++; $display("FAIL fwd_exmem got fa=%b fb=%b exp 10/01", fa, fb); end
    tick();
    idle();
    wb_wn = 4'd4; wb_regwrite = 1'b1;
    mem_wn = 4'd6; mem_regwrite = 1'b1;
    ex_rn1 = 4'd1; ex_rn2 = 4'd4;
    #1;
    total++; if (fa !== 2'b01 || fb !== 2'b00) begin bad++; $display("FAIL fwd_wb got fa=%b fb=%b exp 01/00", fa, fb); end
    // Both stages write r4: EX/MEM must win.
    mem_wn = 4'd4; ex_rn1 = 4'd4;
    #1;
    total++; if (fa !== 2'b10 || fb !== 2'b10) begin bad++; $display("FAIL fwd_prio got fa=%b fb=%b exp 10/10", fa, fb); end
    // EX/MEM not writing: fall back to WB.
    mem_regwrite = 1'b0;
    #1;
    total++; if (fa !== 2'b00 || fb !== 2'b00) begin bad++; $display("FAIL fwd_nowe got fa=%b fb=%b exp 00/00", fa, fb); end
    tick();
  endtask

  // LW r4 ; ADD r6,r4,r1
  task automatic test_load_use();
    idle();
    ex_wn = 4'd4; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_rn1 = 4'd4; id_rn2 = 4'd1; id_uses_rn2 = 1'b1;
    #1;
    total++; if (ctl !== C_LU) begin bad++; $display("FAIL lu_stall got=%b exp=%b", ctl, C_LU); end
    tick();
    idle();
    mem_wn = 4'd4; mem_regwrite = 1'b1;
    id_rn1 = 4'd4; id_rn2 = 4'd1; id_uses_rn2 = 1'b1;
    #1;
    total++; if (ctl !== C_NORMAL) begin bad++; $display("FAIL lu_release got=%b exp=%b", ctl, C_NORMAL); end
    tick();
    idle();
    wb_wn = 4'd4; wb_regwrite = 1'b1; wb_memtoreg = 1'b1;
    ex_rn1 = 4'd4; ex_rn2 = 4'd1;
    #1;
    total++; if (fa !== 2'b00 || fb !== 2'b01) begin bad++; $display("FAIL lu_fwd got fa=%b fb=%b exp 00/01", fa, fb); end
    // rn2 hazard only counts when the instruction reads rn2.
    idle();
    ex_wn = 4'd9; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_rn1 = 4'd1; id_rn2 = 4'd9; id_uses_rn2 = 1'b0;
    #1;
    total++; if (ctl !== C_NORMAL) begin bad++; $display("FAIL lu_rn2_unused got=%b exp=%b", ctl, C_NORMAL); end
    id_uses_rn2 = 1'b1;
    #1;
    total++; if (ctl !== C_LU) begin bad++; $display("FAIL lu_rn2_used got=%b exp=%b", ctl, C_LU); end
    ex_regwrite = 1'b0;
    #1;
    total++; if (ctl !== C_NORMAL) begin bad++; $display("FAIL lu_nowe got=%b exp=%b", ctl, C_NORMAL); end
    tick();
  endtask

  task automatic test_multi();
    idle();
    ex_multi = 1'b1; br_taken = 1'b1;
    ex_rn1 = 4'd3; mem_wn = 4'd3; mem_regwrite = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      total++; if (ctl !== C_FREEZE) begin bad++; $display("FAIL multi_cyc%0d got=%b exp=%b", c, ctl, C_FREEZE); end
      tick();
      // Forwarding keeps tracking while frozen: move the producer to WB.
      mem_regwrite = 1'b0; wb_wn = 4'd3; wb_regwrite = 1'b1;
      #1;
      total++; if (fa !== 2'b00) begin bad++; $display("FAIL multi_fa%0d got=%b exp=00", c, fa); end
      mem_regwrite = 1'b1; wb_regwrite = 1'b0;
    end
    // Op drains out of ID/EX this cycle (ex_multi still high): no re-freeze.
    br_taken = 1'b0;
    #1;
    total++; if (ctl !== C_NORMAL) begin bad++; $display("FAIL multi_drain got=%b exp=%b", ctl, C_NORMAL); end
    tick();
    idle();
    #1;
    total++; if (ctl !== C_NORMAL) begin bad++; $display("FAIL multi_after got=%b exp=%b", ctl, C_NORMAL); end
    tick();
  endtask

  task automatic test_branch();
    idle();
    br_taken = 1'b1;
    ex_wn = 4'd5; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_rn1 = 4'd5;
    #1;
    total++; if (ctl !== C_BRANCH) begin bad++; $display("FAIL br_over_lu got=%b exp=%b", ctl, C_BRANCH); end
    tick();
    idle();
    #1;
    total++; if (ctl !== C_NORMAL) begin bad++; $display("FAIL br_after got=%b exp=%b", ctl, C_NORMAL); end
    tick();
  endtask

  task automatic test_r0_and_reset_busy();
    idle();
    mem_wn = 4'd0; mem_regwrite = 1'b1;
    wb_wn = 4'd0; wb_regwrite = 1'b1;
    ex_rn1 = 4'd0; ex_rn2 = 4'd0;
    #1;
    total++; if (fa !== 2'b01 || fb !== 2'b01) begin bad++; $display("FAIL r0_fwd got fa=%b fb=%b exp 01/01", fa, fb); end
    idle();
    ex_wn = 4'd0; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_rn1 = 4'd0; id_rn2 = 4'd0; id_uses_rn2 = 1'b1;
    #1;
    total++; if (ctl !== C_NORMAL) begin bad++; $display("FAIL r0_no_stall got=%b exp=%b", ctl, C_NORMAL); end
    tick();
    idle();
    ex_multi = 1'b1;
    #1;
    total++; if (ex_busy !== 1'b1) begin bad++; $display("FAIL rb_start got=%b exp=1", ex_busy); end
    tick();
    reset = 1'b1;
    #1;
    total++; if (ctl !== C_RESET) begin bad++; $display("FAIL rb_inreset got=%b exp=%b", ctl, C_RESET); end
    tick();
    reset = 1'b0;
    ex_multi = 1'b0;
    #1;
    total++; if (ctl !== C_NORMAL) begin bad++; $display("FAIL rb_run got=%b exp=%b", ctl, C_NORMAL); end
    tick();
  endtask

  // LW r7 ; SW r7,0(r2)
  task automatic test_store_fwd();
    idle();
    ex_wn = 4'd7; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_rn1 = 4'd2; id_rn2 = 4'd7; id_uses_rn2 = 1'b1; id_memwrite = 1'b1;
    #1;
    total++; if (ctl !== (STF ? C_NORMAL : C_LU)) begin bad++; $display("FAIL st_lu got=%b exp=%b", ctl, STF ? C_NORMAL : C_LU); end
    tick();
    idle();
    mem_wn = 4'd7; mem_regwrite = 1'b1;
    ex_rn1 = 4'd2; ex_rn2 = 4'd7;
    tick();
    idle();
    wb_wn = 4'd7; wb_regwrite = 1'b1; wb_memtoreg = 1'b1;
    mem_memwrite = 1'b1; ex_rn2 = 4'd3;
    #1;
    total++; if (st_fwd !== 1'b0) begin bad++; $display("FAIL st_early got=%b exp=0", st_fwd); end
    tick();
    idle();
    #1;
    total++; if (st_fwd !== STF) begin bad++; $display("FAIL st_fwd got=%b exp=%b", st_fwd, STF); end
    tick();
    #1;
    total++; if (st_fwd !== 1'b0) begin bad++; $display("FAIL st_clear got=%b exp=0", st_fwd); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_multi();
    test_branch();
    test_r0_and_reset_busy();
    test_store_fwd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
